// File: rtl/CPU_Defines.sv
// Shared CPU execute-stage definitions: multiply/divide opcodes and decode helpers.
package cpu_defines_pkg;

    typedef enum logic [2:0] {
        MUL    = 3'd0,
        MULH   = 3'd1,
        MULHSU = 3'd2,
        MULHU  = 3'd3,
        DIV    = 3'd4,
        DIVU   = 3'd5,
        REM    = 3'd6,
        REMU   = 3'd7
    } muldiv_op_t;

    function automatic logic op_is_div(input muldiv_op_t op);
        return op inside {DIV, DIVU, REM, REMU};
    endfunction

    function automatic logic op_is_rem(input muldiv_op_t op);
        return op inside {REM, REMU};
    endfunction

    function automatic logic op1_signed(input muldiv_op_t op);
        return op inside {MUL, MULH, MULHSU, DIV, REM};
    endfunction

    function automatic logic op2_signed(input muldiv_op_t op);
        return op inside {MUL, MULH, DIV, REM};
    endfunction

    function automatic logic op_is_signed_div(input muldiv_op_t op);
        return op inside {DIV, REM};
    endfunction

endpackage

// File: rtl/cpu_muldiv_unit_div_step.sv
// Combinational restoring divide producing DIV_BITS quotient bits, MSB first.
module cpu_div_step #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned DIV_BITS = 1
) (
    input  logic [WIDTH-1:0]    i_rem,
    input  logic [DIV_BITS-1:0] i_bits,
    input  logic [WIDTH-1:0]    i_divisor,
    output logic [WIDTH-1:0]    o_rem,
    output logic [DIV_BITS-1:0] o_quot
);

    logic [WIDTH-1:0] rem_v;
    logic [WIDTH:0]   trial_v;

    always_comb begin
        rem_v   = i_rem;
        trial_v = '0;
        o_quot  = '0;
        for (int i = int'(DIV_BITS) - 1; i >= 0; i--) begin
            trial_v = {rem_v, i_bits[i]};
            if (trial_v >= {1'b0, i_divisor}) begin
                trial_v   = trial_v - {1'b0, i_divisor};
                o_quot[i] = 1'b1;
            end
            // Restored remainder is always below the divisor, so it fits WIDTH bits.
            rem_v = trial_v[WIDTH-1:0];
        end
        o_rem = rem_v;
    end

endmodule

// File: rtl/cpu_muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide,
// sign fixup on magnitudes, early completion for divide special cases, abort on flush.
module cpu_muldiv_unit
    import cpu_defines_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned TAG_WIDTH = 8,
    parameter int unsigned MUL_BITS  = 4,
    parameter int unsigned DIV_BITS  = 1
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_request,
    output logic                 o_ready,
    input  muldiv_op_t           i_op,
    input  logic [TAG_WIDTH-1:0] i_tag,
    input  logic [WIDTH-1:0]     i_op1,
    input  logic [WIDTH-1:0]     i_op2,
    input  logic                 i_abort,
    output logic                 o_valid,
    output logic [TAG_WIDTH-1:0] o_tag,
    output logic [WIDTH-1:0]     o_result
);

    localparam int unsigned MUL_ITERS = WIDTH / MUL_BITS;
    localparam int unsigned DIV_ITERS = WIDTH / DIV_BITS;
    localparam int unsigned CNT_W     = $clog2(WIDTH + 1);
    localparam int unsigned SUM_W     = WIDTH + MUL_BITS;
    localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIXUP, S_DONE} state_t;

    state_t                 state_q, state_d;
    logic [2*WIDTH-1:0]     acc_q, acc_d;      // mul: {partial, multiplier}; div: {remainder, dividend/quotient}
    logic [WIDTH-1:0]       opb_q, opb_d;      // multiplicand or divisor magnitude
    muldiv_op_t             op_q, op_d;
    logic [TAG_WIDTH-1:0]   tag_q, tag_d;
    logic                   neg_q, neg_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0]       result_q, result_d;
    logic [TAG_WIDTH-1:0]   otag_q, otag_d;

    logic                   accept_c, sign1_c, sign2_c, div_zero_c, div_ovf_c;
    logic [WIDTH-1:0]       mag1_c, mag2_c;
    logic [SUM_W-1:0]       mul_sum_c;
    logic [2*WIDTH-1:0]     mul_next_c, div_next_c, prod_fix_c;
    logic [WIDTH-1:0]       div_rem_c, quo_fix_c, rem_fix_c, fix_result_c;
    logic [DIV_BITS-1:0]    div_quot_c;

    assign o_ready  = !i_reset && (state_q == S_IDLE || state_q == S_DONE);
    assign o_valid  = !i_reset && !i_abort && (state_q == S_DONE);
    assign o_result = result_q;
    assign o_tag    = otag_q;
    assign accept_c = i_request && o_ready && !i_abort;

    // Operand magnitudes and divide special-case detection at accept.
    always_comb begin
        sign1_c    = i_op1[WIDTH-1] && op1_signed(i_op);
        sign2_c    = i_op2[WIDTH-1] && op2_signed(i_op);
        mag1_c     = sign1_c ? -i_op1 : i_op1;
        mag2_c     = sign2_c ? -i_op2 : i_op2;
        div_zero_c = op_is_div(i_op) && (i_op2 == '0);
        div_ovf_c  = op_is_signed_div(i_op) && (i_op1 == MIN_INT) && (i_op2 == '1);
    end

    // One shift-add multiply step over MUL_BITS multiplier bits.
    always_comb begin
        mul_sum_c = SUM_W'(acc_q[2*WIDTH-1:WIDTH]);
        for (int j = 0; j < int'(MUL_BITS); j++) begin
            if (acc_q[j]) begin
                mul_sum_c = mul_sum_c + (SUM_W'(opb_q) << j);
            end
        end
        mul_next_c = (2*WIDTH)'({mul_sum_c, acc_q[WIDTH-1:0]} >> MUL_BITS);
    end

    cpu_div_step #(
        .WIDTH    (WIDTH),
        .DIV_BITS (DIV_BITS)
    ) u_div_step (
        .i_rem     (acc_q[2*WIDTH-1:WIDTH]),
        .i_bits    (acc_q[WIDTH-1 -: DIV_BITS]),
        .i_divisor (opb_q),
        .o_rem     (div_rem_c),
        .o_quot    (div_quot_c)
    );

    assign div_next_c = {div_rem_c, (acc_q[WIDTH-1:0] << DIV_BITS) | WIDTH'(div_quot_c)};

    // Sign fixup and result selection.
    always_comb begin
        prod_fix_c = neg_q ? -acc_q : acc_q;
        quo_fix_c  = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix_c  = neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        case (op_q)
            MUL:                 fix_result_c = prod_fix_c[WIDTH-1:0];
            MULH, MULHSU, MULHU: fix_result_c = prod_fix_c[2*WIDTH-1:WIDTH];
            DIV, DIVU:           fix_result_c = quo_fix_c;
            default:             fix_result_c = rem_fix_c;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        op_d     = op_q;
        tag_d    = tag_q;
        neg_d    = neg_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        otag_d   = otag_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (accept_c) begin
                    op_d    = i_op;
                    tag_d   = i_tag;
                    neg_d   = op_is_rem(i_op) ? sign1_c : (sign1_c ^ sign2_c);
                    state_d = S_RUN;
                    if (op_is_div(i_op)) begin
                        acc_d = {{WIDTH{1'b0}}, mag1_c};
                        opb_d = mag2_c;
                        cnt_d = CNT_W'(DIV_ITERS);
                    end else begin
                        acc_d = {{WIDTH{1'b0}}, mag2_c};
                        opb_d = mag1_c;
                        cnt_d = CNT_W'(MUL_ITERS);
                    end
                    // Special cases preload the final {remainder, quotient} unsigned.
                    if (div_zero_c) begin
                        acc_d   = {i_op1, {WIDTH{1'b1}}};
                        neg_d   = 1'b0;
                        state_d = S_FIXUP;
                    end else if (div_ovf_c) begin
                        acc_d   = {{WIDTH{1'b0}}, MIN_INT};
                        neg_d   = 1'b0;
                        state_d = S_FIXUP;
                    end
                end
            end
            S_RUN: begin
                acc_d = op_is_div(op_q) ? div_next_c : mul_next_c;
                cnt_d = cnt_q - CNT_W'(1);
                if (i_abort) begin
                    state_d = S_IDLE;
                end else if (cnt_q == CNT_W'(1)) begin
                    state_d = S_FIXUP;
                end
            end
            S_FIXUP: begin
                if (i_abort) begin
                    state_d = S_IDLE;
                end else begin
                    state_d  = S_DONE;
                    result_d = fix_result_c;
                    otag_d   = tag_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            opb_q    <= '0;
            op_q     <= MUL;
            tag_q    <= '0;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            otag_q   <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            opb_q    <= opb_d;
            op_q     <= op_d;
            tag_q    <= tag_d;
            neg_q    <= neg_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            otag_q   <= otag_d;
        end
    end

endmodule

// File: tb/tb_cpu_muldiv_unit.sv
// Self-checking bench for cpu_muldiv_unit: directed RV32M cases plus randomized
// traffic with aborts and resets, checked against an arithmetic reference model.
module tb_cpu_muldiv_unit;
    import cpu_defines_pkg::*;

    localparam int unsigned W  = 32;
    localparam int unsigned TW = 8;
    localparam logic [W-1:0] MIN_INT = 32'h8000_0000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req = 1'b0;
    logic          abort = 1'b0;
    muldiv_op_t    op = MUL;
    logic [TW-1:0] tag = '0;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          ready, valid;
    logic [TW-1:0] otag;
    logic [W-1:0]  res;

    always #5 clk = ~clk;

    cpu_muldiv_unit #(
        .WIDTH     (W),
        .TAG_WIDTH (TW),
        .MUL_BITS  (4),
        .DIV_BITS  (1)
    ) dut (
        .i_clock   (clk),
        .i_reset   (rst),
        .i_request (req),
        .o_ready   (ready),
        .i_op      (op),
        .i_tag     (tag),
        .i_op1     (a),
        .i_op2     (b),
        .i_abort   (abort),
        .o_valid   (valid),
        .o_tag     (otag),
        .o_result  (res)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: at most one operation in flight, completing at done_cyc.
    int            cyc = 0;
    bit            pend = 0;
    int            done_cyc = 0;
    logic [W-1:0]  m_res = '0;
    logic [TW-1:0] m_tag = '0;
    bit            m_has_lit = 0;
    logic [W-1:0]  m_lit = '0;
    bit            accepted = 0;
    bit            lit_arm = 0;
    logic [W-1:0]  lit_val = '0;
    bit            chk_zero = 0;

    function automatic logic [W-1:0] ref_result(muldiv_op_t o, logic [W-1:0] x, logic [W-1:0] y);
        longint     sx, sy, uy;
        logic [63:0] p;
        int          ix, iy;
        bit          ovf;
        sx  = longint'($signed(x));
        sy  = longint'($signed(y));
        uy  = longint'({32'h0, y});
        ix  = $signed(x);
        iy  = $signed(y);
        ovf = (x == MIN_INT) && (y == 32'hFFFF_FFFF);
        case (o)
            MUL:    begin p = 64'(sx * sy); return p[31:0]; end
            MULH:   begin p = 64'(sx * sy); return p[63:32]; end
            MULHSU: begin p = 64'(sx * uy); return p[63:32]; end
            MULHU:  begin p = {32'h0, x} * {32'h0, y}; return p[63:32]; end
            DIV:    return (y == 0) ? 32'hFFFF_FFFF : ovf ? MIN_INT : 32'(ix / iy);
            DIVU:   return (y == 0) ? 32'hFFFF_FFFF : x / y;
            REM:    return (y == 0) ? x : ovf ? 32'h0 : 32'(ix % iy);
            default: return (y == 0) ? x : x % y;
        endcase
    endfunction

    function automatic int ref_latency(muldiv_op_t o, logic [W-1:0] x, logic [W-1:0] y);
        if (!(o inside {DIV, DIVU, REM, REMU})) return 10;
        if (y == 0) return 2;
        if ((o inside {DIV, REM}) && x == MIN_INT && y == 32'hFFFF_FFFF) return 2;
        return 34;
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, exp);
        end
    endtask

    // Compare process: checks at negedge, advances the model at posedge.
    initial begin
        bit exp_v, exp_r, acc;
        forever begin
            @(negedge clk);
            exp_v = pend && (done_cyc == cyc) && !abort && !rst;
            exp_r = !rst && (!pend || done_cyc == cyc);
            chk("o_valid", 64'(valid), 64'(exp_v));
            chk("o_ready", 64'(ready), 64'(exp_r));
            if (exp_v && valid) begin
                chk("o_result", 64'(res), 64'(m_res));
                chk("o_tag", 64'(otag), 64'(m_tag));
                if (m_has_lit) chk("o_result_literal", 64'(res), 64'(m_lit));
            end
            if (chk_zero) begin
                chk("reset_result", 64'(res), 64'h0);
                chk("reset_tag", 64'(otag), 64'h0);
                chk_zero = 0;
            end
            @(posedge clk);
            acc = req && !rst && !abort && (!pend || done_cyc == cyc);
            accepted = acc;
            if (rst) begin
                pend = 0;
            end else if (acc) begin
                pend      = 1;
                m_res     = ref_result(op, a, b);
                m_tag     = tag;
                done_cyc  = cyc + ref_latency(op, a, b);
                m_has_lit = lit_arm;
                m_lit     = lit_val;
            end else if (abort || (pend && done_cyc == cyc)) begin
                pend = 0;
            end
            cyc++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(muldiv_op_t o, logic [W-1:0] x, logic [W-1:0] y, logic [TW-1:0] t,
                         bit has_lit, logic [W-1:0] lit);
        op = o; a = x; b = y; tag = t; req = 1'b1;
        lit_arm = has_lit; lit_val = lit;
        for (int k = 0; k < 100; k++) begin
            step();
            if (accepted) break;
        end
        if (!accepted) begin
            n_bad++;
            $display("FAIL issue_timeout at cycle %0d: got no accept, expected accept", cyc);
        end
        req = 1'b0; lit_arm = 0;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 60 && pend; k++) step();
        if (pend) begin
            n_bad++;
            $display("FAIL completion_timeout at cycle %0d: got busy, expected idle", cyc);
        end
        step();
    endtask

    function automatic logic [W-1:0] rand_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return MIN_INT;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 15));
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        // Pin the reference model to hand-computed values.
        chk("pin_mulhu",  64'(ref_result(MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF)), 64'hFFFF_FFFE);
        chk("pin_mulhsu", 64'(ref_result(MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF)), 64'hFFFF_FFFF);
        chk("pin_rem",    64'(ref_result(REM,    32'hFFFF_FFF9, 32'h2)),         64'hFFFF_FFFF);
        chk("pin_divlat", 64'(ref_latency(DIV,   32'hFFFF_FFF9, 32'h2)),         64'd34);

        repeat (3) step();
        rst = 1'b0; chk_zero = 1;
        step();

        issue(MUL,    32'd7,         32'hFFFF_FFFD, 8'h5A, 1, 32'hFFFF_FFEB); wait_idle();
        issue(MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'h01, 1, 32'hFFFF_FFFE); wait_idle();
        issue(MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'h02, 1, 32'h0000_0000); wait_idle();
        issue(MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'h03, 1, 32'hFFFF_FFFF); wait_idle();
        issue(DIV,    32'hFFFF_FFF9, 32'd2,         8'h04, 1, 32'hFFFF_FFFD); wait_idle();
        issue(REM,    32'hFFFF_FFF9, 32'd2,         8'h05, 1, 32'hFFFF_FFFF); wait_idle();
        issue(DIVU,   32'hFFFF_FFF9, 32'd2,         8'h06, 1, 32'h7FFF_FFFC); wait_idle();
        issue(DIVU,   32'd5,         32'd0,         8'h07, 1, 32'hFFFF_FFFF); wait_idle();
        issue(REMU,   32'd5,         32'd0,         8'h08, 1, 32'd5);         wait_idle();
        issue(DIV,    MIN_INT,       32'hFFFF_FFFF, 8'h09, 1, MIN_INT);       wait_idle();
        issue(REM,    MIN_INT,       32'hFFFF_FFFF, 8'h0A, 1, 32'h0);         wait_idle();

        // Back-to-back: second request is held while busy and taken in the DONE cycle.
        issue(MUL, 32'd1234, 32'd5678, 8'h10, 1, 32'd7006652);
        issue(DIV, 32'd1000, 32'd7,    8'h11, 1, 32'd142);
        issue(REMU, 32'd1000, 32'd7,   8'h12, 1, 32'd6);
        wait_idle();

        // Abort mid-divide, then a multiply straight after.
        issue(DIV, 32'd100, 32'd7, 8'h20, 0, '0);
        repeat (4) step();
        abort = 1'b1; step(); abort = 1'b0;
        issue(MUL, 32'd3, 32'd9, 8'h21, 1, 32'd27);
        repeat (40) step();

        // Reset in the middle of a multiply.
        issue(MUL, 32'd11, 32'd13, 8'h30, 0, '0);
        repeat (2) step();
        rst = 1'b1; step(); rst = 1'b0; chk_zero = 1;
        step();
        wait_idle();

        // Randomized traffic with occasional aborts and resets.
        for (int c = 0; c < 3000; c++) begin
            req   = ($urandom_range(0, 1) == 1);
            op    = muldiv_op_t'($urandom_range(0, 7));
            a     = rand_operand();
            b     = rand_operand();
            tag   = TW'($urandom);
            abort = ($urandom_range(0, 99) == 0);
            rst   = ($urandom_range(0, 399) == 0);
            step();
        end
        req = 1'b0; abort = 1'b0; rst = 1'b0;
        repeat (50) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
